// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Holds the FSM state enum, requester IDs and the default timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam int unsigned TIMEOUT_DEF = 32'd255;
  localparam int unsigned WSTRB_W     = 32'd4;

  // Width of a counter that must hold values 0..t; a zero timeout still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned t);
    if (t > 32'd0) begin
      return $clog2(t + 32'd1);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Two-way winner selection between fetch and load-store requesters.
// MEM_ARB_RR_EN selects round-robin ties; otherwise data always wins ties.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic last_id_i,
`endif
  output logic any_req_o,
  output logic win_id_o
);

  // Combinational pick; a lone requester always wins.
  always_comb begin
    any_req_o = if_req_i | d_req_i;
    win_id_o  = REQ_IF;
    if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
      win_id_o = (last_id_i == REQ_IF) ? REQ_D : REQ_IF;
`else
      win_id_o = REQ_D;
`endif
    end else if (d_req_i) begin
      win_id_o = REQ_D;
    end else begin
      win_id_o = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch and a load-store requester onto one memory port.
// Optional round-robin tie-break enabled with MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32'd32,
  parameter int unsigned DATA_W  = 32'd32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_gnt,
  output logic               if_done,
  output logic               if_err,
  output logic [DATA_W-1:0]  if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  input  logic [WSTRB_W-1:0] d_wstrb,
  output logic               d_gnt,
  output logic               d_done,
  output logic               d_err,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [WSTRB_W-1:0] mem_wstrb,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT > 32'd0) ? (TIMEOUT - 32'd1) : 32'd0);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [WSTRB_W-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic                if_gnt_q, if_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                if_done_q, if_done_d;
  logic                d_done_q, d_done_d;
  logic                if_err_q, if_err_d;
  logic                d_err_q, d_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;
  logic                any_req_s;
  logic                win_id_s;
  logic                timeout_hit_s;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // Round-robin pointer follows every grant.
  always_comb begin
    last_d = last_q;
    if ((state_q == ST_IDLE) && any_req_s) begin
      last_d = win_id_s;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset means fetch was served last so data wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_IF;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_req_i  (if_req),
    .d_req_i   (d_req),
`ifdef MEM_ARB_RR_EN
    .last_id_i (last_q),
`endif
    .any_req_o (any_req_s),
    .win_id_o  (win_id_s)
  );

  assign timeout_hit_s = (TIMEOUT != 32'd0) && (cnt_q == TO_LAST);

  // Next-state and output computation; pulses default low, data registers hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (any_req_s && (win_id_s == REQ_D)) begin
          state_d     = ST_BUSY_D;
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
        end else if (any_req_s) begin
          state_d     = ST_BUSY_IF;
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = {DATA_W{1'b0}};
          mem_wstrb_d = {WSTRB_W{1'b0}};
        end else begin
          mem_req_d = 1'b0;
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        // A late mem_ready still beats a timeout landing on the same cycle.
        if (mem_ready || timeout_hit_s) begin
          state_d   = ST_IDLE;
          cnt_d     = {CNT_W{1'b0}};
          mem_req_d = 1'b0;
          if (state_q == ST_BUSY_IF) begin
            if_done_d  = 1'b1;
            if_err_d   = ~mem_ready;
            if_rdata_d = mem_ready ? mem_rdata : {DATA_W{1'b0}};
          end else begin
            d_done_d = 1'b1;
            d_err_d  = ~mem_ready;
            if (!mem_ready) begin
              d_rdata_d = {DATA_W{1'b0}};
            end else if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else if (TIMEOUT != 32'd0) begin
          cnt_d = cnt_q + CNT_W'(32'd1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = {CNT_W{1'b0}};
        mem_req_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_wstrb_q <= {WSTRB_W{1'b0}};
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      d_rdata_q   <= {DATA_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=4).
// Arbitration expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_done, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt, d_done, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    tick();
    n_cmp++; if ({busy, mem_req, mem_we, if_gnt, d_gnt, if_done, d_done, if_err, d_err} !== 9'b0) begin n_bad++; $display("FAIL reset_flags: got %b expected %b", {busy, mem_req, mem_we, if_gnt, d_gnt, if_done, d_done, if_err, d_err}, 9'b0); end
    n_cmp++; if ({if_rdata, d_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected %h", {if_rdata, d_rdata}, 64'h0); end
    n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin n_bad++; $display("FAIL reset_mem: got %h expected %h", {mem_addr, mem_wdata, mem_wstrb}, 68'h0); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({busy, mem_req} !== 2'b00) begin n_bad++; $display("FAIL reset_idle: got %b expected %b", {busy, mem_req}, 2'b00); end
  endtask

  task automatic test_lone_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    n_cmp++; if ({if_gnt, d_gnt, mem_req, busy} !== 4'b1011) begin n_bad++; $display("FAIL fetch_gnt: got %b expected %b", {if_gnt, d_gnt, mem_req, busy}, 4'b1011); end
    n_cmp++; if (mem_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_addr: got %h expected %h", mem_addr, 32'h100); end
    n_cmp++; if ({mem_we, mem_wstrb} !== 5'b0) begin n_bad++; $display("FAIL fetch_we_strb: got %b expected %b", {mem_we, mem_wstrb}, 5'b0); end
    if_req = 1'b0;
    tick();
    n_cmp++; if ({if_gnt, mem_req, if_done} !== 3'b010) begin n_bad++; $display("FAIL fetch_wait: got %b expected %b", {if_gnt, mem_req, if_done}, 3'b010); end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    n_cmp++; if ({if_done, if_err, mem_req, busy, d_done} !== 5'b10000) begin n_bad++; $display("FAIL fetch_done: got %b expected %b", {if_done, if_err, mem_req, busy, d_done}, 5'b10000); end
    n_cmp++; if (if_rdata !== 32'h00500093) begin n_bad++; $display("FAIL fetch_rdata: got %h expected %h", if_rdata, 32'h00500093); end
    tick();
    n_cmp++; if ({if_done, if_rdata} !== {1'b0, 32'h00500093}) begin n_bad++; $display("FAIL fetch_hold: got %h expected %h", {if_done, if_rdata}, {1'b0, 32'h00500093}); end
  endtask

  task automatic test_load();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    tick();
    d_req = 1'b0;
    n_cmp++; if ({d_gnt, if_gnt, mem_req, mem_we} !== 4'b1010) begin n_bad++; $display("FAIL load_gnt: got %b expected %b", {d_gnt, if_gnt, mem_req, mem_we}, 4'b1010); end
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ready = 1'b0;
    n_cmp++; if ({d_done, d_err, d_rdata} !== {2'b10, 32'h12345678}) begin n_bad++; $display("FAIL load_done: got %h expected %h", {d_done, d_err, d_rdata}, {2'b10, 32'h12345678}); end
    n_cmp++; if (if_rdata !== 32'h00500093) begin n_bad++; $display("FAIL load_if_rdata_kept: got %h expected %h", if_rdata, 32'h00500093); end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    tick();
    n_cmp++; if ({d_gnt, mem_req, mem_we, mem_wstrb} !== 7'b1110011) begin n_bad++; $display("FAIL store_gnt: got %b expected %b", {d_gnt, mem_req, mem_we, mem_wstrb}, 7'b1110011); end
    n_cmp++; if ({mem_addr, mem_wdata} !== {32'h200, 32'hDEADBEEF}) begin n_bad++; $display("FAIL store_fields: got %h expected %h", {mem_addr, mem_wdata}, {32'h200, 32'hDEADBEEF}); end
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'b0;
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata} !== {2'b11, 4'b0011, 32'h200, 32'hDEADBEEF}) begin n_bad++; $display("FAIL store_stable: got %h expected %h", {mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata}, {2'b11, 4'b0011, 32'h200, 32'hDEADBEEF}); end
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ready = 1'b0;
    n_cmp++; if ({d_done, d_err, mem_req} !== 3'b100) begin n_bad++; $display("FAIL store_done: got %b expected %b", {d_done, d_err, mem_req}, 3'b100); end
    n_cmp++; if (d_rdata !== 32'h12345678) begin n_bad++; $display("FAIL store_rdata_kept: got %h expected %h", d_rdata, 32'h12345678); end
  endtask

  task automatic test_ready_idle();
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    tick();
    n_cmp++; if ({if_done, d_done, busy, mem_req} !== 4'b0) begin n_bad++; $display("FAIL idle_ready_flags: got %b expected %b", {if_done, d_done, busy, mem_req}, 4'b0); end
    n_cmp++; if ({if_rdata, d_rdata} !== {32'h00500093, 32'h12345678}) begin n_bad++; $display("FAIL idle_ready_rdata: got %h expected %h", {if_rdata, d_rdata}, {32'h00500093, 32'h12345678}); end
    mem_ready = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_d;
`ifdef MEM_ARB_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    apply_reset();
    if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if ({d_gnt, if_gnt} !== {exp_d[i], ~exp_d[i]}) begin n_bad++; $display("FAIL arb_gnt_%0d: got %b expected %b", i, {d_gnt, if_gnt}, {exp_d[i], ~exp_d[i]}); end
      n_cmp++; if (mem_addr !== (exp_d[i] ? 32'h500 : 32'h400)) begin n_bad++; $display("FAIL arb_addr_%0d: got %h expected %h", i, mem_addr, (exp_d[i] ? 32'h500 : 32'h400)); end
      mem_ready = 1'b1; mem_rdata = 32'h1000 + 32'(i);
      tick();
      mem_ready = 1'b0;
      n_cmp++; if ({d_done, if_done} !== {exp_d[i], ~exp_d[i]}) begin n_bad++; $display("FAIL arb_done_%0d: got %b expected %b", i, {d_done, if_done}, {exp_d[i], ~exp_d[i]}); end
      if (i == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    tick();
    n_cmp++; if ({busy, mem_req} !== 2'b00) begin n_bad++; $display("FAIL arb_idle: got %b expected %b", {busy, mem_req}, 2'b00); end
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    tick();
    d_req = 1'b0;
    n_cmp++; if ({d_gnt, mem_req} !== 2'b11) begin n_bad++; $display("FAIL to_gnt: got %b expected %b", {d_gnt, mem_req}, 2'b11); end
    n_cmp++; if (d_rdata === 32'h0) begin n_bad++; $display("FAIL to_rdata_pre: got %h expected nonzero", d_rdata); end
    tick();
    tick();
    tick();
    n_cmp++; if ({mem_req, d_done, busy} !== 3'b101) begin n_bad++; $display("FAIL to_cycle4: got %b expected %b", {mem_req, d_done, busy}, 3'b101); end
    tick();
    n_cmp++; if ({mem_req, d_done, d_err, busy} !== 4'b0110) begin n_bad++; $display("FAIL to_done: got %b expected %b", {mem_req, d_done, d_err, busy}, 4'b0110); end
    n_cmp++; if (d_rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata: got %h expected %h", d_rdata, 32'h0); end
    tick();
    n_cmp++; if ({d_done, d_err} !== 2'b00) begin n_bad++; $display("FAIL to_err_clear: got %b expected %b", {d_done, d_err}, 2'b00); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    saw_done = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    tick();
    d_req = 1'b0;
    n_cmp++; if ({busy, mem_req, d_gnt} !== 3'b111) begin n_bad++; $display("FAIL mid_busy: got %b expected %b", {busy, mem_req, d_gnt}, 3'b111); end
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, mem_req, mem_we, d_gnt, d_done, d_err, if_done} !== 7'b0) begin n_bad++; $display("FAIL mid_async: got %b expected %b", {busy, mem_req, mem_we, d_gnt, d_done, d_err, if_done}, 7'b0); end
    n_cmp++; if ({mem_addr, d_rdata, if_rdata} !== 96'h0) begin n_bad++; $display("FAIL mid_async_data: got %h expected %h", {mem_addr, d_rdata, if_rdata}, 96'h0); end
    mem_ready = 1'b1;
    tick();
    saw_done = saw_done | d_done;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    saw_done = saw_done | d_done;
    tick();
    saw_done = saw_done | d_done;
    n_cmp++; if ({saw_done, busy} !== 2'b00) begin n_bad++; $display("FAIL mid_no_done: got %b expected %b", {saw_done, busy}, 2'b00); end
    if_req = 1'b1; if_addr = 32'h800;
    tick();
    if_req = 1'b0;
    n_cmp++; if ({if_gnt, mem_req, mem_addr} !== {2'b11, 32'h800}) begin n_bad++; $display("FAIL mid_next_gnt: got %h expected %h", {if_gnt, mem_req, mem_addr}, {2'b11, 32'h800}); end
    mem_ready = 1'b1; mem_rdata = 32'h0000A5A5;
    tick();
    mem_ready = 1'b0;
    n_cmp++; if ({if_done, if_err, if_rdata} !== {2'b10, 32'h0000A5A5}) begin n_bad++; $display("FAIL mid_next_done: got %h expected %h", {if_done, if_err, if_rdata}, {2'b10, 32'h0000A5A5}); end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_load();
    test_store();
    test_ready_idle();
    test_arbitration();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 255, max wait cycles for mem_ready (0 = no timeout).
REQ-002 SHALL use one clock and an asynchronous active-low reset, as listed in REQ-003 and REQ-004.
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 if_req / if_addr  input  1 / ADDR_W  instruction-fetch read request, address.
REQ-006 if_gnt / if_done / if_err  output  1 each  fetch accepted pulse, completion pulse, timeout flag.
REQ-007 if_rdata  output  DATA_W  fetched word.
REQ-008 d_req / d_we / d_addr / d_wdata / d_wstrb  input  1/1/ADDR_W/DATA_W/4  load-store request.
REQ-009 d_gnt / d_done / d_err  output  1 each; d_rdata  output  DATA_W  load-store grant, completion, error, read data.
REQ-010 mem_req / mem_we / mem_addr / mem_wdata / mem_wstrb  output  1/1/ADDR_W/DATA_W/4  single memory port.
REQ-011 mem_ready / mem_rdata  input  1 / DATA_W  memory completion, read data.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D.
REQ-014 In IDLE with any request sampled, SHALL pick a winner, register its address, write data, strobe and we, and go to BUSY_IF or BUSY_D.
REQ-015 SHALL pulse the winner's gnt and assert mem_req in the first BUSY cycle, which is one cycle after the request is sampled.
REQ-016 SHALL hold mem_req and all mem_* fields stable until mem_ready is sampled high.
REQ-017 For a fetch, mem_we SHALL be 0 and mem_wstrb SHALL be 4'b0000.
REQ-018 On mem_ready, SHALL drop mem_req and return to IDLE.
REQ-019 The done pulse SHALL occur in the following cycle.
REQ-020 For a read, rdata SHALL be updated from mem_rdata captured on mem_ready.
REQ-021 For a write, d_rdata SHALL be unchanged.
REQ-022 rdata SHALL hold until the next read completion for that requester.
REQ-023 Minimum spacing: mem_ready at cycle M -> done at M+1 (in IDLE, arbitration occurs at M+1) -> next gnt/mem_req at M+2.
REQ-024 A requester SHALL hold req until gnt; req changes while the FSM is busy SHALL be ignored.
REQ-025 With TIMEOUT>0, a counter SHALL count BUSY cycles with mem_ready low.
REQ-026 When the counter reaches TIMEOUT, SHALL drop mem_req, return to IDLE, pulse done with err=1 and load rdata with 0.
REQ-027 err SHALL be valid only with done.
REQ-028 mem_ready while in IDLE SHALL be ignored.

Reset
REQ-029 On rst_n low, SHALL force state IDLE and set all outputs and rdata registers to 0.
REQ-030 On rst_n low, SHALL clear the timeout counter and set the round-robin pointer to "last served = fetch".
REQ-031 Reset mid-transaction SHALL abandon the transaction with no done pulse.

Configuration
REQ-032 With MEM_ARB_RR_EN defined, simultaneous requests SHALL go to the requester not served last; the pointer SHALL update on every grant, and the first tie after reset goes to data.
REQ-033 Without MEM_ARB_RR_EN, the data requester SHALL always win ties.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum, requester ID constants (REQ_IF=0, REQ_D=1) and the TIMEOUT default.
REQ-035 Winner selection SHALL live in sub-module mem_arb_pick (2-way fixed/round-robin pick).

Verification
REQ-036 Lone fetch if_addr=0x100, mem_ready 2 cycles after mem_req, mem_rdata=0x00500093 -> if_gnt at +1, mem_addr=0x100, mem_we=0, if_done with if_rdata=0x00500093, if_err=0.
REQ-037 Store d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 -> mem_we=1 and mem_wstrb=4'b0011 held until mem_ready; d_done pulses; d_rdata unchanged.
REQ-038 Both requesting continuously for 4 transactions -> with MEM_ARB_RR_EN grants D,IF,D,IF; without it grants D,D,D,D.
REQ-039 TIMEOUT=4, mem_ready never asserted -> mem_req drops after 4 cycles; d_done=1, d_err=1, d_rdata=0; busy=0 next cycle.
REQ-040 rst_n pulled low during BUSY_D -> all outputs 0 immediately; no d_done; the next if_req is served normally.
